// File: rtl/sram_pkg.sv
// Shared definitions for the multi-beat SRAM controller.
//   sram_state_t : controller FSM state encoding (IDLE, SETUP, STROBE, DONE)
//   beats()      : number of SRAM beats needed per CPU word
//   DEF_*        : default parameter values for the controller
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } sram_state_t;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SRAM_DW     = 16;
  localparam int DEF_SRAM_AW     = 18;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_WAIT_CYCLES = 2;

  function automatic int beats(input int data_w, input int sram_dw);
    return data_w / sram_dw;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter used for both strobe wait states and beat counting.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over en)
//   en        : decrement by one, saturating at zero
//   count     : current value
//   last      : high while the count is zero
module sram_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, saturating decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign last  = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/sram_multibeat_ctrl.sv
// MEM-stage to asynchronous SRAM bridge. Each CPU word is split into BEATS
// SRAM accesses of SETUP (1 cycle) + STROBE (WAIT_CYCLES cycles).
//   clk, rst                 : clock, synchronous active-high reset
//   mem_w_en, mem_r_en       : request levels, held until ready (write wins)
//   address, write_data      : CPU byte address and store data
//   byte_en                  : store byte enables (ignored on reads)
//   ready, addr_err          : completion / idle, and out-of-range flag
//   read_data                : last completed read word (registered)
//   sram_addr, sram_dq       : SRAM word address and bidirectional data
//   sram_ce_n/oe_n/we_n/ub_n/lb_n : active-low SRAM strobes
module sram_multibeat_ctrl
  import sram_pkg::*;
#(
  parameter int          DATA_W      = DEF_DATA_W,
  parameter int          SRAM_DW     = DEF_SRAM_DW,
  parameter int          SRAM_AW     = DEF_SRAM_AW,
  parameter logic [31:0] BASE_ADDR   = 32'(DEF_BASE_ADDR),
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_w_en,
  input  logic                mem_r_en,
  input  logic [31:0]         address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                ready,
  output logic                addr_err,
  output logic [DATA_W-1:0]   read_data,
  output logic [SRAM_AW-1:0]  sram_addr,
  inout  wire  [SRAM_DW-1:0]  sram_dq,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n
);

  localparam int BEATS = beats(DATA_W, SRAM_DW);
  localparam int BSH   = $clog2(DATA_W / 8);
  localparam int BPB   = SRAM_DW / 8;
  localparam int BCW   = $clog2(BEATS + 1);
  localparam int WCW   = $clog2(WAIT_CYCLES + 1);

  sram_state_t         state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic                err_q, err_d;
  logic [SRAM_AW-1:0]  base_q, base_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                req_s;
  logic [31:0]         rel_s;
  logic [63:0]         word_s;
  logic                err_s;
  logic [BCW-1:0]      beat_cnt_s;
  logic [BCW-1:0]      beat_s;
  logic                beat_last_s;
  logic [WCW-1:0]      wait_cnt_s;
  logic                wait_last_s;
  logic [BPB-1:0]      be_slice_s;
  logic [SRAM_DW-1:0]  dq_out_s;
  logic                dq_oe_s;

  assign req_s = mem_w_en | mem_r_en;

  // Range check: word offset scaled to SRAM words must fit the SRAM; done in
  // 64 bits so large addresses cannot wrap back into range.
  always_comb begin
    rel_s  = address - BASE_ADDR;
    word_s = 64'(rel_s >> BSH) * 64'(BEATS);
    err_s  = (address < BASE_ADDR) || (word_s >= (64'd1 << SRAM_AW));
  end

  // Beat counter runs BEATS-1 down to 0, so the beat index is its complement.
  sram_wait_counter #(.W(BCW)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_q == ST_IDLE) && req_s),
    .en       ((state_q == ST_STROBE) && wait_last_s),
    .load_val (BCW'(BEATS - 1)),
    .count    (beat_cnt_s),
    .last     (beat_last_s)
  );

  sram_wait_counter #(.W(WCW)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == ST_SETUP),
    .en       (state_q == ST_STROBE),
    .load_val (WCW'(WAIT_CYCLES - 1)),
    .count    (wait_cnt_s),
    .last     (wait_last_s)
  );

  assign beat_s     = BCW'(BEATS - 1) - beat_cnt_s;
  assign be_slice_s = be_q[int'(beat_s)*BPB +: BPB];
  assign dq_out_s   = wdata_q[int'(beat_s)*SRAM_DW +: SRAM_DW];
  assign dq_oe_s    = is_wr_q && ((state_q == ST_SETUP) || (state_q == ST_STROBE));
  assign sram_dq    = dq_oe_s ? dq_out_s : {SRAM_DW{1'bz}};
  assign read_data  = rdata_q;

  // Next-state, request latching and read-beat capture.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          is_wr_d = mem_w_en;
          err_d   = err_s;
          base_d  = word_s[SRAM_AW-1:0];
          wdata_d = write_data;
          be_d    = byte_en;
          state_d = err_s ? ST_DONE : ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        if (wait_last_s) begin
          if (!is_wr_q) begin
            rdata_d[int'(beat_s)*SRAM_DW +: SRAM_DW] = sram_dq;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = beat_last_s ? ST_DONE : ST_SETUP;
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= {SRAM_AW{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      be_q    <= {(DATA_W/8){1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobe, address and handshake decode from registered state.
  always_comb begin
    ready     = 1'b0;
    addr_err  = 1'b0;
    sram_addr = {SRAM_AW{1'b0}};
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_ub_n = 1'b1;
    sram_lb_n = 1'b1;
    case (state_q)
      ST_IDLE: ready = !req_s;
      ST_SETUP, ST_STROBE: begin
        sram_addr = base_q + SRAM_AW'(beat_s);
        sram_ce_n = 1'b0;
        if (state_q == ST_STROBE) begin
          sram_we_n = !is_wr_q;
          sram_oe_n = is_wr_q;
        end else begin
          sram_we_n = 1'b1;
          sram_oe_n = 1'b1;
        end
        if (is_wr_q) begin
          sram_lb_n = ~be_slice_s[0];
          sram_ub_n = (BPB > 1) ? ~be_slice_s[BPB-1] : 1'b1;
        end else begin
          sram_lb_n = 1'b0;
          sram_ub_n = (BPB > 1) ? 1'b0 : 1'b1;
        end
      end
      ST_DONE: begin
        ready    = 1'b1;
        addr_err = err_q;
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_multibeat_ctrl.sv
// Scoreboard bench for sram_multibeat_ctrl: dut_a uses defaults (16-bit SRAM,
// 2 wait states), dut_b uses an 8-bit SRAM with 1 wait state. Both share the
// request bus; sel routes requests to one of them.
module tb_sram_multibeat_ctrl;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
    logic        ub;
    logic        lb;
    int          n;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, sel, preload, w_en, r_en;
  logic [31:0] address, write_data;
  logic [3:0]  byte_en;

  logic        ready_a, err_a, ce_a, oe_a, we_a, ub_a, lb_a;
  logic [31:0] rd_a;
  logic [17:0] addr_a;
  wire  [15:0] dq_a;
  logic        ready_b, err_b, ce_b, oe_b, we_b, ub_b, lb_b;
  logic [31:0] rd_b;
  logic [17:0] addr_b;
  wire  [7:0]  dq_b;

  logic [15:0] mem16 [0:15];
  logic [7:0]  mem8  [0:15];

  resp_t exp_q[$];
  beat_t exp_b[$];
  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  int    act_cnt = 0;
  int    ubl_cnt = 0;

  always #5 clk = ~clk;

  sram_multibeat_ctrl dut_a (
    .clk(clk), .rst(rst), .mem_w_en(w_en & ~sel), .mem_r_en(r_en & ~sel),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .ready(ready_a), .addr_err(err_a), .read_data(rd_a), .sram_addr(addr_a),
    .sram_dq(dq_a), .sram_ce_n(ce_a), .sram_oe_n(oe_a), .sram_we_n(we_a),
    .sram_ub_n(ub_a), .sram_lb_n(lb_a)
  );

  sram_multibeat_ctrl #(.SRAM_DW(8), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .mem_w_en(w_en & sel), .mem_r_en(r_en & sel),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .ready(ready_b), .addr_err(err_b), .read_data(rd_b), .sram_addr(addr_b),
    .sram_dq(dq_b), .sram_ce_n(ce_b), .sram_oe_n(oe_b), .sram_we_n(we_b),
    .sram_ub_n(ub_b), .sram_lb_n(lb_b)
  );

  // SRAM models: byte-lane writes while CE/WE low, read drive while OE low.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        mem16[i] <= 16'h0000;
        mem8[i]  <= 8'h00;
      end
      mem16[2] <= 16'h1234;
      mem16[3] <= 16'h5678;
    end else begin
      if (!ce_a && !we_a) begin
        if (!lb_a) mem16[addr_a[3:0]][7:0]  <= dq_a[7:0];
        if (!ub_a) mem16[addr_a[3:0]][15:8] <= dq_a[15:8];
      end
      if (!ce_b && !we_b && !lb_b) mem8[addr_b[3:0]] <= dq_b;
    end
  end

  assign dq_a = (!ce_a && !oe_a && we_a) ? mem16[addr_a[3:0]] : 16'hzzzz;
  assign dq_b = (!ce_b && !oe_b && we_b) ? mem8[addr_b[3:0]] : 8'hzz;

  // Undriven dq_a reads as all ones, which makes high-Z observable.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu (dq_a[i]);
  end

  // Views of whichever DUT is selected.
  logic        ready_m, err_m, ce_m, oe_m, we_m, ub_m, lb_m;
  logic [31:0] rd_m;
  logic [17:0] addr_m;
  logic [15:0] dq_m;
  assign ready_m = sel ? ready_b : ready_a;
  assign err_m   = sel ? err_b : err_a;
  assign rd_m    = sel ? rd_b : rd_a;
  assign ce_m    = sel ? ce_b : ce_a;
  assign oe_m    = sel ? oe_b : oe_a;
  assign we_m    = sel ? we_b : we_a;
  assign ub_m    = sel ? ub_b : ub_a;
  assign lb_m    = sel ? lb_b : lb_a;
  assign addr_m  = sel ? addr_b : addr_a;
  assign dq_m    = sel ? {8'h00, dq_b} : dq_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resp_mon();
    int    cyc = 0;
    resp_t e;
    forever begin
      @(negedge clk);
      if (!(w_en || r_en)) begin
        cyc = 0;
      end else if (ready_m) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", 64'(rd_m), 64'(e.rd));
          chk("addr_err", 64'(err_m), 64'(e.err));
          chk("latency", 64'(cyc), 64'(e.lat));
        end
        done_cnt++;
        cyc = 0;
      end else begin
        cyc++;
      end
    end
  endtask

  task automatic beat_mon();
    logic  in_b = 1'b0;
    int    n = 0;
    beat_t cap, e;
    forever begin
      @(negedge clk);
      if (!ce_m || !oe_m || !we_m || !ub_m || !lb_m) act_cnt++;
      if (sel && !ub_b) ubl_cnt++;
      if (!ce_m && !we_m) begin
        if (!in_b) begin
          cap.a = addr_m; cap.d = dq_m; cap.ub = ub_m; cap.lb = lb_m;
          in_b = 1'b1;
          n = 1;
        end else begin
          n++;
        end
      end else if (in_b) begin
        in_b = 1'b0;
        if (exp_b.size() == 0) begin
          chk("beat_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_b.pop_front();
          chk("beat_addr", 64'(cap.a), 64'(e.a));
          chk("beat_dq", 64'(cap.d), 64'(e.d));
          chk("beat_ub_lb", 64'({cap.ub, cap.lb}), 64'({e.ub, e.lb}));
          chk("beat_we_cycles", 64'(n), 64'(e.n));
        end
      end
    end
  endtask

  task automatic eb(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb, input int n);
    exp_b.push_back('{a: a, d: d, ub: ub, lb: lb, n: n});
  endtask

  task automatic txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] erd, input logic eerr, input int elat);
    int start;
    int n;
    exp_q.push_back('{rd: erd, err: eerr, lat: elat});
    @(posedge clk);
    #1;
    w_en = w; r_en = r; address = a; write_data = wd; byte_en = be;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start) begin
      chk("ready_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
    #1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  initial begin
    int a0;
    rst = 1'b1; preload = 1'b1; sel = 1'b0; w_en = 1'b0; r_en = 1'b0;
    address = 32'h0; write_data = 32'h0; byte_en = 4'h0;
    fork
      resp_mon();
      beat_mon();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; preload = 1'b0;

    @(negedge clk);
    chk("rst_ready", 64'(ready_a), 64'd1);
    chk("rst_addr_err", 64'(err_a), 64'd0);
    chk("rst_read_data", 64'(rd_a), 64'd0);
    chk("rst_strobes", 64'({ce_a, oe_a, we_a, ub_a, lb_a}), 64'h1F);
    chk("rst_sram_addr", 64'(addr_a), 64'd0);
    chk("rst_dq_hiz", 64'(dq_a), 64'hFFFF);

    eb(18'd0, 16'hBEEF, 1'b0, 1'b0, 2);
    eb(18'd1, 16'hDEAD, 1'b0, 1'b0, 2);
    txn(1'b1, 1'b0, 32'h400, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 7);
    txn(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 7);

    eb(18'd2, 16'h0000, 1'b1, 1'b1, 2);
    eb(18'd3, 16'h00AA, 1'b1, 1'b0, 2);
    txn(1'b1, 1'b0, 32'h404, 32'h00AA0000, 4'b0100, 32'hDEADBEEF, 1'b0, 7);
    txn(1'b0, 1'b1, 32'h404, 32'h0, 4'h0, 32'h56AA1234, 1'b0, 7);

    a0 = act_cnt;
    txn(1'b1, 1'b0, 32'h3FC, 32'h11111111, 4'hF, 32'h56AA1234, 1'b1, 1);
    chk("err_no_strobes", 64'(act_cnt - a0), 64'd0);

    eb(18'd4, 16'hF00D, 1'b0, 1'b0, 2);
    eb(18'd5, 16'hCAFE, 1'b0, 1'b0, 2);
    txn(1'b1, 1'b1, 32'h408, 32'hCAFEF00D, 4'hF, 32'h56AA1234, 1'b0, 7);

    eb(18'h3FFFE, 16'h2468, 1'b0, 1'b0, 2);
    eb(18'h3FFFF, 16'h1357, 1'b0, 1'b0, 2);
    txn(1'b1, 1'b0, 32'h803FC, 32'h13572468, 4'hF, 32'h56AA1234, 1'b0, 7);
    txn(1'b0, 1'b1, 32'h803FC, 32'h0, 4'h0, 32'h13572468, 1'b0, 7);
    a0 = act_cnt;
    txn(1'b0, 1'b1, 32'h80400, 32'h0, 4'h0, 32'h13572468, 1'b1, 1);
    chk("err_hi_no_strobes", 64'(act_cnt - a0), 64'd0);
    txn(1'b0, 1'b1, 32'h408, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 7);

    // Reset while the second beat of a read is strobing.
    @(posedge clk);
    #1;
    r_en = 1'b1; address = 32'h400;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_oe_low", 64'(oe_a), 64'd0);
    rst = 1'b1; r_en = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes", 64'({ce_a, oe_a, we_a, ub_a, lb_a}), 64'h1F);
    chk("mid_rst_dq_hiz", 64'(dq_a), 64'hFFFF);
    chk("mid_rst_read_data", 64'(rd_a), 64'd0);
    chk("mid_rst_ready", 64'(ready_a), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    txn(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 7);

    // 8-bit SRAM, one wait state: four beats per word.
    @(posedge clk);
    #1;
    sel = 1'b1;
    eb(18'd0, 16'h0044, 1'b1, 1'b0, 1);
    eb(18'd1, 16'h0033, 1'b1, 1'b0, 1);
    eb(18'd2, 16'h0022, 1'b1, 1'b0, 1);
    eb(18'd3, 16'h0011, 1'b1, 1'b0, 1);
    txn(1'b1, 1'b0, 32'h400, 32'h11223344, 4'hF, 32'h0, 1'b0, 9);
    txn(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'h11223344, 1'b0, 9);
    chk("ub_held_high_8bit", 64'(ubl_cnt), 64'd0);

    repeat (2) @(posedge clk);
    chk("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("beat_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_multibeat_ctrl.md
# sram_multibeat_ctrl

Parametrised successor to the single-word SRAM controller. It bridges the 32-bit MEM-stage load/store interface to an external asynchronous SRAM whose data bus is narrower than the CPU word, splitting each access into several SRAM beats. It adds configurable wait states, byte-enable writes through UB/LB, base-address relocation and an address-range error flag. It sits between the MEM stage and the board SRAM pins; the pipeline stalls while `ready` is low.

## Interface
- `DATA_W`, 32: CPU word width; multiple of `SRAM_DW`.
- `SRAM_DW`, 16: SRAM data width, 16 or 8; `BEATS = DATA_W/SRAM_DW`.
- `SRAM_AW`, 18: SRAM address width, in SRAM words.
- `BASE_ADDR`, 1024: CPU byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 2: active-strobe cycles per beat, ≥1.
- `clk` in 1: clock. `rst` in 1: reset, synchronous, active-high.
- `mem_w_en` in 1 / `mem_r_en` in 1: request levels, held until `ready`.
- `address` in 32: CPU byte address; low log2(DATA_W/8) bits ignored.
- `write_data` in DATA_W: store data.
- `byte_en` in DATA_W/8: store byte enables; ignored on reads.
- `ready` out 1: high when idle, or for one cycle on completion.
- `addr_err` out 1: high with `ready` when the request was out of range.
- `read_data` out DATA_W: last completed read word, registered.
- `sram_addr` out SRAM_AW, `sram_dq` inout SRAM_DW.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1: active-low strobes. With `SRAM_DW=8`, `sram_ub_n` is held high.

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE: if `mem_w_en` or `mem_r_en`, go to SETUP with beat = 0. If both are high, the write wins.
- Range check in IDLE: word offset `off = (address - BASE_ADDR) >> log2(DATA_W/8)`. The request is an error if `address < BASE_ADDR` or `off*BEATS >= 2**SRAM_AW`. An error goes straight to DONE with `addr_err=1`; there is no SRAM cycle and `read_data` is unchanged.
- SETUP, 1 cycle:
  - `sram_addr = off*BEATS + beat`.
  - `ce_n=0`, `we_n=1`, `oe_n=1`.
  - On a write, `sram_dq` is driven with slice `beat` (beat 0 is the low `SRAM_DW` bits).
- STROBE, `WAIT_CYCLES` cycles:
  - Write: `we_n=0`, data and address held stable.
  - Read: `oe_n=0`; `sram_dq` is sampled into slice `beat` of `read_data` on the last STROBE cycle.
  - After the last STROBE cycle: go to SETUP with beat+1, or to DONE if beat == BEATS-1.
- UB/LB during a write beat: the negation of the `byte_en` bits covering that beat. During a read, both are 0.
- A write beat whose byte enables are all zero still takes its cycles, with UB=LB=1.
- DONE, 1 cycle: `ready=1`, then IDLE. The requester drops or changes its request on the cycle after `ready`.
- `sram_dq` is high-Z except during write SETUP/STROBE.
- `address`, `write_data` and `byte_en` are latched in IDLE and are not re-sampled mid-access.

## Timing
- Latency from request (seen in IDLE) to `ready`: `1 + BEATS*(1+WAIT_CYCLES)` cycles. Defaults give 7 cycles.
- Out-of-range request: `ready` 1 cycle after the request.
- IDLE with no request: `ready=1` combinationally. In SETUP and STROBE: `ready=0`.
- Back-to-back requests: DONE→IDLE costs one cycle, so a new access starts at the earliest 2 cycles after the previous `ready`.
- Reset values: state IDLE, `read_data=0`, `addr_err=0`, `ready=1`, all strobes 1, `sram_addr=0`, `sram_dq` high-Z.
- Reset mid-access: the next cycle is IDLE with all strobes high. A partial write is possible and is not recovered.

## Structure
- Shared package `sram_pkg`: state enum `sram_state_t`, function `beats(DATA_W,SRAM_DW)`, and localparam defaults.
- Sub-module `sram_wait_counter`: loadable down-counter.
  - Load value `WAIT_CYCLES-1`.
  - Outputs `last` on zero.
  - Reused for beat counting with load value `BEATS-1`.

## Test plan
- Write 0xDEADBEEF at 0x400, `byte_en=4'hF`, defaults:
  - 2 beats, `sram_addr` 0 then 1, dq 0xBEEF then 0xDEAD.
  - `we_n` low for 2 cycles per beat.
  - `ready` at cycle 7.
- Read back 0x400 with the model returning the stored data: `read_data=0xDEADBEEF` at `ready`, cycle 7.
- Write at 0x404 with `byte_en=4'b0100`, data 0x00AA0000:
  - beat 0 (addr 2) has UB=LB=1.
  - beat 1 (addr 3) has LB=0, UB=1, dq 0x00AA.
- Write to address 0x3FC: `addr_err=1` and `ready` one cycle later, with no strobe activity.
- `mem_w_en` and `mem_r_en` both high: a write cycle is performed and `read_data` is unchanged.
- `rst` during STROBE of beat 1:
  - next cycle all strobes are 1, dq is high-Z, `read_data=0`.
  - a fresh read then completes normally.
- `WAIT_CYCLES=1`, `SRAM_DW=8`: 4 beats, latency 9 cycles, `sram_ub_n` stays high.
